// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder slice.
// Holds the FSM state encoding, default sizing and the address-check helper.
package dmem_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } state_e;

  localparam int unsigned DefaultDepth   = 64;
  localparam int unsigned DefaultLatency = 2;
  localparam logic [7:0]  ERRCOUNT_MAX   = 8'd255;

  // Misaligned or beyond the last stored word.
  function automatic logic bad_addr(logic [31:0] addr, int unsigned depth);
    return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage: synchronous write, asynchronous read.
// No reset; contents are undefined until written.
module dmem_array #(
  parameter int unsigned Depth = 64,
  parameter int unsigned IdxW  = 6
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [IdxW-1:0] idx_i,
  input  logic [31:0]     wdata_i,
  output logic [31:0]     rdata_o
);

  logic [31:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Target end of the load/store interface: one word access per Req/Ready handshake,
// with LATENCY wait states, error responses for bad addresses and a saturating error count.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = DefaultDepth,
  parameter int unsigned LATENCY = DefaultLatency
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        Err,
  output logic [7:0]  ErrCount
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CntW-1:0] CntInit = (LATENCY > 0) ? CntW'(LATENCY - 1) : '0;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            we_q, we_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [7:0]      errcnt_q, errcnt_d;

  logic            do_access, do_err, acc_we, mem_we, bad;
  logic [IdxW-1:0] acc_idx;
  logic [31:0]     acc_wdata, mem_rdata;

  assign bad = bad_addr(Addr, DEPTH);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    do_access = 1'b0;
    do_err    = 1'b0;
    acc_we    = we_q;
    acc_idx   = idx_q;
    acc_wdata = wdata_q;
    unique case (state_q)
      StIdle: begin
        if (Req) begin
          we_d      = MemWrite;
          idx_d     = Addr[IdxW+1:2];
          wdata_d   = WriteData;
          // Zero-latency accesses use the live inputs on the acceptance edge.
          acc_we    = MemWrite;
          acc_idx   = Addr[IdxW+1:2];
          acc_wdata = WriteData;
          if (bad) begin
            do_err  = 1'b1;
            state_d = StResp;
          end else if (LATENCY == 0) begin
            do_access = 1'b1;
            state_d   = StResp;
          end else begin
            cnt_d   = CntInit;
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          do_access = 1'b1;
          state_d   = StResp;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rdata_d  = rdata_q;
    err_d    = err_q;
    errcnt_d = errcnt_q;
    if (do_err) begin
      rdata_d = '0;
      err_d   = 1'b1;
      if (errcnt_q != ERRCOUNT_MAX) begin
        errcnt_d = errcnt_q + 8'd1;
      end
    end else if (do_access) begin
      rdata_d = acc_we ? '0 : mem_rdata;
      err_d   = 1'b0;
    end
  end

  // Reset wins over a pending store on the same edge.
  assign mem_we = do_access & acc_we & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      errcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      idx_q    <= idx_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      errcnt_q <= errcnt_d;
    end
  end

  dmem_array #(
    .Depth (DEPTH),
    .IdxW  (IdxW)
  ) u_array (
    .clk_i   (clk),
    .we_i    (mem_we),
    .idx_i   (acc_idx),
    .wdata_i (acc_wdata),
    .rdata_o (mem_rdata)
  );

  assign Ready    = (state_q == StResp);
  assign Err      = err_q;
  assign ReadData = rdata_q;
  assign ErrCount = errcnt_q;

endmodule
